// File: rtl/stdp_pkg.sv
// Shared constants, FSM state encoding and row-address helper for the STDP weight updater.
package stdp_pkg;

  localparam int N_ROW     = 24;
  localparam int N_LANE    = 24;
  localparam int N_NRN     = 18;
  localparam int TRC_W     = 16;
  localparam int W_W       = 8;
  localparam int LTP_SHIFT = 4;
  localparam int LTD_SHIFT = 4;

  localparam int N_ADDR = N_ROW * N_NRN;
  localparam int ADDR_W = $clog2(N_ADDR);
  localparam int ROW_W  = $clog2(N_ROW);
  localparam int NRN_W  = $clog2(N_NRN);
  // Two guard bits: one for the LTP carry above the weight, one for sign after LTD.
  localparam int SUM_W  = TRC_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [NRN_W-1:0] nrn,
                                                 input logic [ROW_W-1:0] row);
    return ADDR_W'(nrn) * ADDR_W'(N_ROW) + ADDR_W'(row);
  endfunction

endpackage

// File: rtl/stdp_weight_update_if.sv
// Pre-synaptic beat stream, post-neuron state and weight SRAM port bundle.
// slave = updater side, master = stream source / memory side.
interface stdp_weight_update_if;
  import stdp_pkg::*;

  logic                      i_start;
  logic                      i_valid;
  logic [N_LANE-1:0]         i_spike_bundle;
  logic [N_LANE*TRC_W-1:0]   i_trace;
  logic [N_NRN-1:0]          i_post_spike;
  logic [N_NRN*TRC_W-1:0]    i_post_trace;
  logic                      o_w_ren;
  logic [ADDR_W-1:0]         o_w_raddr;
  logic [N_LANE*W_W-1:0]     i_w_rdata;
  logic                      o_w_wen;
  logic [ADDR_W-1:0]         o_w_waddr;
  logic [N_LANE*W_W-1:0]     o_w_wdata;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_err;

  modport slave (
    input  i_start, i_valid, i_spike_bundle, i_trace, i_post_spike, i_post_trace, i_w_rdata,
    output o_w_ren, o_w_raddr, o_w_wen, o_w_waddr, o_w_wdata, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_valid, i_spike_bundle, i_trace, i_post_spike, i_post_trace, i_w_rdata,
    input  o_w_ren, o_w_raddr, o_w_wen, o_w_waddr, o_w_wdata, o_busy, o_done, o_err
  );

endinterface

// File: rtl/stdp_lane_update.sv
// One synapse lane: w + LTP - LTD, clamped to the unsigned weight range.
// Purely combinational; no handshake.
module stdp_lane_update
  import stdp_pkg::*;
(
  input  logic [W_W-1:0]   w,
  input  logic [TRC_W-1:0] pre_trace,
  input  logic [TRC_W-1:0] post_trace,
  input  logic             pre_spike,
  input  logic             post_spike,
  output logic [W_W-1:0]   w_new
);

  localparam logic signed [SUM_W-1:0] W_MAX_S = SUM_W'((1 << W_W) - 1);

  logic signed [SUM_W-1:0] ltp;
  logic signed [SUM_W-1:0] ltd;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    ltp = post_spike ? $signed(SUM_W'(pre_trace >> LTP_SHIFT)) : '0;
    ltd = pre_spike  ? $signed(SUM_W'(post_trace >> LTD_SHIFT)) : '0;
    sum = $signed({{(SUM_W-W_W){1'b0}}, w}) + ltp - ltd;
    if (sum < 0) begin
      w_new = '0;
    end else if (sum > W_MAX_S) begin
      w_new = '1;
    end else begin
      w_new = sum[W_W-1:0];
    end
  end

endmodule

// File: rtl/stdp_weight_update.sv
// Pair-based STDP row updater: read at beat cycle T, write back at T+2, 1 beat/cycle.
// No backpressure: every i_valid in RUN is consumed; beats outside RUN are dropped and flag o_err.
module stdp_weight_update
  import stdp_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  stdp_weight_update_if.slave bus
);

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
  logic [NRN_W-1:0]        nrn_cnt_q, nrn_cnt_d;
  logic                    drain_q, drain_d;
  logic                    err_q, err_d;

  logic                    s1_vld_q, s1_vld_d;
  logic [N_LANE-1:0]       s1_spk_q, s1_spk_d;
  logic [N_LANE*TRC_W-1:0] s1_trc_q, s1_trc_d;
  logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;
  logic [NRN_W-1:0]        s1_nrn_q, s1_nrn_d;

  logic                    s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0]       s2_addr_q, s2_addr_d;
  logic [N_LANE*W_W-1:0]   s2_dat_q, s2_dat_d;

  logic                    accept;
  logic                    last_row;
  logic                    last_beat;
  logic [ADDR_W-1:0]       beat_addr;
  logic [TRC_W-1:0]        post_trc;
  logic                    post_spk;
  logic [N_LANE*W_W-1:0]   new_row;

  assign accept    = (state_q == ST_RUN) && bus.i_valid;
  assign last_row  = (row_cnt_q == ROW_W'(N_ROW - 1));
  assign last_beat = accept && last_row && (nrn_cnt_q == NRN_W'(N_NRN - 1));
  assign beat_addr = row_addr(nrn_cnt_q, row_cnt_q);

  // Post-neuron state is held stable by the source for the whole pass.
  assign post_trc = bus.i_post_trace[s1_nrn_q*TRC_W +: TRC_W];
  assign post_spk = bus.i_post_spike[s1_nrn_q];

  for (genvar j = 0; j < N_LANE; j++) begin : g_lane
    stdp_lane_update u_lane (
      .w          (bus.i_w_rdata[j*W_W +: W_W]),
      .pre_trace  (s1_trc_q[j*TRC_W +: TRC_W]),
      .post_trace (post_trc),
      .pre_spike  (s1_spk_q[j]),
      .post_spike (post_spk),
      .w_new      (new_row[j*W_W +: W_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    nrn_cnt_d = nrn_cnt_q;
    drain_d   = drain_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d   = ST_RUN;
          row_cnt_d = '0;
          nrn_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (last_row) begin
            row_cnt_d = '0;
            nrn_cnt_d = nrn_cnt_q + 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
        if (last_beat) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.i_valid && (state_q != ST_RUN)) err_d = 1'b1;

    s1_vld_d  = accept;
    s1_spk_d  = s1_spk_q;
    s1_trc_d  = s1_trc_q;
    s1_addr_d = s1_addr_q;
    s1_nrn_d  = s1_nrn_q;
    if (accept) begin
      s1_spk_d  = bus.i_spike_bundle;
      s1_trc_d  = bus.i_trace;
      s1_addr_d = beat_addr;
      s1_nrn_d  = nrn_cnt_q;
    end

    s2_vld_d  = s1_vld_q;
    s2_addr_d = s1_vld_q ? s1_addr_q : s2_addr_q;
    s2_dat_d  = s1_vld_q ? new_row   : s2_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      nrn_cnt_q <= '0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_spk_q  <= '0;
      s1_trc_q  <= '0;
      s1_addr_q <= '0;
      s1_nrn_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      nrn_cnt_q <= nrn_cnt_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      s1_vld_q  <= s1_vld_d;
      s1_spk_q  <= s1_spk_d;
      s1_trc_q  <= s1_trc_d;
      s1_addr_q <= s1_addr_d;
      s1_nrn_q  <= s1_nrn_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      s2_dat_q  <= s2_dat_d;
    end
  end

  // The read strobe is combinational so the SRAM returns data at T+1; hold it low during reset.
  assign bus.o_w_ren   = accept && !rst;
  assign bus.o_w_raddr = (accept && !rst) ? beat_addr : '0;
  assign bus.o_w_wen   = s2_vld_q;
  assign bus.o_w_waddr = s2_addr_q;
  assign bus.o_w_wdata = s2_dat_q;
  assign bus.o_busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.o_done    = (state_q == ST_DONE);
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_stdp_weight_update.sv
// Randomized scoreboard bench for stdp_weight_update with an arithmetic STDP reference model.
module tb_stdp_weight_update;
  import stdp_pkg::*;

  localparam int RW = N_LANE * W_W;
  typedef logic [RW-1:0] row_t;
  typedef struct {
    int   addr;
    row_t data;
    row_t old;
    int   cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stdp_weight_update_if bus ();

  stdp_weight_update dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  row_t mem     [N_ADDR];
  row_t ref_mem [N_ADDR];
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   exp_done_cyc = -1;
  logic [TRC_W-1:0] fix_trc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_r(input string name, input row_t act, input row_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Weight SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.o_w_ren) begin
      rd_cnt++;
      bus.i_w_rdata <= (int'(bus.o_w_raddr) < N_ADDR) ? mem[bus.o_w_raddr] : '0;
    end
  end

  // Monitor: pops the scoreboard on every write and checks done timing.
  always @(negedge clk) begin
    if (bus.o_w_wen) begin
      wr_cnt++;
      if (int'(bus.o_w_waddr) < N_ADDR) mem[bus.o_w_waddr] = bus.o_w_wdata;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, none expected", bus.o_w_waddr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk_i("wr_addr", int'(bus.o_w_waddr), mon_e.addr);
        chk_r("wr_data", bus.o_w_wdata, mon_e.data);
        chk_i("wr_cycle", cyc, mon_e.cyc);
      end
    end
    if (bus.o_done) begin
      done_cnt++;
      chk_i("done_cycle", cyc, exp_done_cyc);
    end
  end

  // Reference STDP rule written from plain integer arithmetic.
  function automatic row_t model_row(input row_t w, input logic [N_LANE-1:0] spk,
                                     input logic [N_LANE*TRC_W-1:0] trc, input int n);
    row_t r;
    for (int j = 0; j < N_LANE; j++) begin
      int v;
      v = int'(w[j*W_W +: W_W]);
      if (bus.i_post_spike[n]) v = v + int'(trc[j*TRC_W +: TRC_W]) / 16;
      if (spk[j])              v = v - int'(bus.i_post_trace[n*TRC_W +: TRC_W]) / 16;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      r[j*W_W +: W_W] = 8'(v);
    end
    return r;
  endfunction

  task automatic preset_all(input logic [W_W-1:0] val);
    for (int a = 0; a < N_ADDR; a++) begin
      mem[a]     = {N_LANE{val}};
      ref_mem[a] = {N_LANE{val}};
    end
  endtask

  task automatic preset_random();
    for (int a = 0; a < N_ADDR; a++) begin
      for (int j = 0; j < N_LANE; j++) mem[a][j*W_W +: W_W] = 8'($urandom_range(0, 255));
      ref_mem[a] = mem[a];
    end
  endtask

  task automatic random_post();
    bus.i_post_spike = N_NRN'($urandom);
    for (int n = 0; n < N_NRN; n++) bus.i_post_trace[n*TRC_W +: TRC_W] = 16'($urandom_range(0, 65535));
  endtask

  task automatic do_reset();
    wr_t d;
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Writes due from this cycle on belong to the aborted pass.
    while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) begin
      d = exp_q.pop_back();
      ref_mem[d.addr] = d.old;
    end
    exp_done_cyc = -1;
    chk_i("rst_wen", int'(bus.o_w_wen), 0);
    chk_i("rst_busy", int'(bus.o_busy), 0);
    chk_i("rst_done", int'(bus.o_done), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: no pre-spikes, fixed trace; 1: all pre-spikes, fixed trace; 2: random.
  task automatic run_pass(input string tag, input int mode, input int gap_pct,
                          input int abort_at, input bit mid_start);
    int d0, w0, r0;
    wr_t e;
    logic [N_LANE-1:0]       spk;
    logic [N_LANE*TRC_W-1:0] trc;
    d0 = done_cnt;
    @(negedge clk);
    w0 = wr_cnt;
    r0 = rd_cnt;
    bus.i_start = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int b = 0; b < N_ADDR; b++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.i_valid = 1'b0;
        bus.i_start = mid_start && ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      if (b == abort_at) begin
        do_reset();
        repeat (6) @(negedge clk);
        chk_i({tag, "_abort_no_done"}, done_cnt - d0, 0);
        return;
      end
      case (mode)
        0: begin spk = '0; trc = {N_LANE{fix_trc}}; end
        1: begin spk = '1; trc = {N_LANE{fix_trc}}; end
        default: begin
          spk = N_LANE'($urandom);
          for (int j = 0; j < N_LANE; j++) trc[j*TRC_W +: TRC_W] = 16'($urandom_range(0, 65535));
        end
      endcase
      bus.i_valid        = 1'b1;
      bus.i_spike_bundle = spk;
      bus.i_trace        = trc;
      bus.i_start        = mid_start && ($urandom_range(0, 7) == 0);
      e.addr = b;
      e.old  = ref_mem[b];
      e.data = model_row(ref_mem[b], spk, trc, b / N_ROW);
      e.cyc  = cyc + 2;
      ref_mem[b] = e.data;
      exp_q.push_back(e);
      if (b == N_ADDR - 1) exp_done_cyc = cyc + 3;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    repeat (6) @(negedge clk);
    chk_i({tag, "_done_count"}, done_cnt - d0, 1);
    chk_i({tag, "_write_count"}, wr_cnt - w0, N_ADDR);
    chk_i({tag, "_read_count"}, rd_cnt - r0, N_ADDR);
    chk_i({tag, "_queue_left"}, exp_q.size(), 0);
    chk_i({tag, "_busy_after"}, int'(bus.o_busy), 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int r0, mism;
    bus.i_start        = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_spike_bundle = '0;
    bus.i_trace        = '0;
    bus.i_post_spike   = '0;
    bus.i_post_trace   = '0;
    fix_trc            = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_i("reset_ren", int'(bus.o_w_ren), 0);
    chk_i("reset_wen", int'(bus.o_w_wen), 0);
    chk_i("reset_busy", int'(bus.o_busy), 0);
    chk_i("reset_done", int'(bus.o_done), 0);
    chk_i("reset_err", int'(bus.o_err), 0);

    // Null pass: nothing fires, every row written back unchanged.
    preset_all(8'h40);
    for (int n = 0; n < N_NRN; n++) bus.i_post_trace[n*TRC_W +: TRC_W] = 16'($urandom_range(0, 65535));
    run_pass("null", 0, 0, -1, 1'b0);
    chk_r("null_row0", mem[0], {N_LANE{8'h40}});
    chk_r("null_row431", mem[431], {N_LANE{8'h40}});

    // LTP on neuron 5 only.
    preset_all(8'h40);
    bus.i_post_spike = N_NRN'(1 << 5);
    fix_trc = 16'h0100;
    run_pass("ltp", 0, 0, -1, 1'b0);
    chk_r("ltp_row120", mem[120], {N_LANE{8'h50}});
    chk_r("ltp_row143", mem[143], {N_LANE{8'h50}});
    chk_r("ltp_row119", mem[119], {N_LANE{8'h40}});
    chk_r("ltp_row144", mem[144], {N_LANE{8'h40}});

    // Clamps: neuron 0 LTD below zero, neuron 1 LTP above full scale.
    for (int a = 0; a < N_ADDR; a++) begin
      mem[a] = (a < N_ROW) ? {N_LANE{8'h10}} : {N_LANE{8'hF0}};
      ref_mem[a] = mem[a];
    end
    bus.i_post_spike = N_NRN'(1 << 1);
    bus.i_post_trace = '0;
    bus.i_post_trace[0 +: TRC_W] = 16'h0800;
    fix_trc = 16'hFFF0;
    run_pass("clamp", 1, 0, -1, 1'b0);
    chk_r("clamp_lo_row0", mem[0], {N_LANE{8'h00}});
    chk_r("clamp_hi_row24", mem[24], {N_LANE{8'hFF}});
    chk_r("clamp_other_row48", mem[48], {N_LANE{8'hF0}});

    // Gapped random stream with stray i_start pulses during RUN.
    preset_random();
    random_post();
    run_pass("gapped", 2, 50, -1, 1'b1);

    // Beats while idle are dropped and flagged; the next start clears the flag.
    @(negedge clk);
    r0 = rd_cnt;
    bus.i_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk_i("idle_no_read", rd_cnt - r0, 0);
    chk_i("idle_err_set", int'(bus.o_err), 1);
    chk_i("idle_no_busy", int'(bus.o_busy), 0);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk_i("start_clears_err", int'(bus.o_err), 0);
    chk_i("start_busy", int'(bus.o_busy), 1);
    // Already in RUN: the pass's own start pulse must be ignored.
    random_post();
    run_pass("restart_in_run", 2, 20, -1, 1'b0);
    chk_i("err_stays_clear", int'(bus.o_err), 0);

    // Reset mid-pass at beat 200, then a full pass from address 0.
    preset_random();
    random_post();
    run_pass("abort", 2, 0, 200, 1'b0);
    run_pass("after_abort", 2, 10, -1, 1'b0);

    mism = 0;
    for (int a = 0; a < N_ADDR; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk_i("final_mem_rows_mismatched", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
